keccak_padder_stream: RTL and testbench
=======================================

Name: keccak_padder_stream

Overview:
- Sequential Keccak pad10*1 padder that packs a byte-granular word stream into full rate-sized blocks for the permutation core.
- Generalises the single-word combinational padder:
  - parametrised word width and rate;
  - word counter and block shift register;
  - automatic zero-fill padding cycles;
  - final-bit insertion;
  - full/ack handshake to the f-permutation.
- Sits between the message source (Kyber SHA3/SHAKE front end) and the Keccak-f core.

Parameters:
- IN_W, 32, input word width in bits; multiple of 8, at least 16.
- RATE_BITS, 1088, block rate in bits; multiple of IN_W. 1088 is SHA3-256; 1344 is SHAKE128.
- SUFFIX, 8'h06, domain-separation byte inserted after the last message byte.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in  in  IN_W  message word, big-endian bytes; first byte in [IN_W-1:IN_W-8].
- in_ready  in  1  "in" valid this cycle.
- is_last  in  1  this word is the final word of the message.
- byte_num  in  $clog2(IN_W/8)  number of valid bytes when is_last=1 (0..IN_W/8-1).
- buffer_full  out  1  padder cannot accept input this cycle.
- out  out  RATE_BITS  assembled block; first word in the MSBs.
- out_ready  out  1  out holds a complete block.
- f_ack  in  1  permutation has consumed out.

Behaviour:
- Reset:
  - out=0, out_ready=0, buffer_full=0;
  - word counter cnt=0;
  - state=ACCEPT.
  - Reset asserted in any state, including mid-PAD or FULL, discards the partial block.
- WORDS=RATE_BITS/IN_W; cnt is $clog2(WORDS) bits wide.
- A word is accepted when in_ready=1 and buffer_full=0.
- Accepting a word:
  - out <= {out[RATE_BITS-IN_W-1:0], w}; cnt++.
  - When cnt reaches WORDS, cnt wraps to 0 and the next state is FULL.
- Word formation, non-last: w=in.
- Word formation, last:
  - keep the top byte_num bytes of in;
  - byte at index byte_num = SUFFIX;
  - lower bytes = 0.
  - byte_num=0 gives w = SUFFIX followed by zeros; "in" is ignored.
  - A message whose length is a multiple of the word size ends with an is_last word with byte_num=0.
- Final bit: the last word of a block that follows the last message word has its LSB byte ORed with 8'h80. When suffix and final byte coincide this yields 8'h86.
- States:
  - ACCEPT:
    - takes words.
    - On an accepted last word: go to FULL if the block is complete, otherwise go to PAD.
  - PAD:
    - buffer_full=1.
    - Shifts in one zero word per cycle; the block's final word is 32'h00000080-style (only the 8'h80 byte set).
    - Goes to FULL once WORDS words are held.
  - FULL:
    - out_ready=1, buffer_full=1, out stable.
    - f_ack moves to ACCEPT next cycle with cnt=0.
    - A new message starts fresh after the padded block is acknowledged.
- in_ready while buffer_full=1: the word is ignored; the source must hold it.
- f_ack outside FULL: ignored.
- f_ack together with in_ready in FULL: the word is not taken that cycle.
- Latency:
  - out_ready rises the cycle after the block-completing word is accepted.
  - A last word at cnt=k gives WORDS-1-k PAD cycles before FULL.

Optional Feature:
- Macro: KECCAK_PADDER_SUFFIX_PORT_EN.
- Defined: adds input suffix[7:0], sampled with the accepted is_last word; it replaces the SUFFIX parameter, allowing runtime SHA3 (06) or SHAKE (1F) selection.
- Undefined: the port is absent and the SUFFIX parameter is used.

Decomposition:
- Package keccak_pkg holds:
  - state enum {ACCEPT, PAD, FULL};
  - constants SHA3_SUFFIX=8'h06, SHAKE_SUFFIX=8'h1F, PAD_FINAL=8'h80;
  - rate constants for SHA3-256, SHA3-512, SHAKE128 and SHAKE256.
- One sub-module: keccak_pad_word, the combinational last-word formatter (in, byte_num, suffix -> w). It is a parametrised IN_W generalisation of the existing word padder.

Test Plan:
- IN_W=32, RATE_BITS=64: send 0x90ABCDEF, then last 0x12xxxxxx with byte_num=1 -> next cycle out_ready=1, out=64'h90ABCDEF_12060080.
- RATE_BITS=64: first word is last with byte_num=0 -> one PAD cycle, then out=64'h06000000_00000080; buffer_full high during PAD.
- RATE_BITS=64: 0x11223344, then last 0xAABBCCDD with byte_num=3 -> out=64'h11223344_AABBCC86.
- RATE_BITS=64: two full non-last words with in_ready held -> out_ready=1, third word ignored until f_ack; it is accepted the cycle after ack and is word 0 of the next block.
- Default RATE_BITS=1088: last word at cnt=2 -> exactly 31 PAD cycles; then assert reset_n=0 during a later PAD -> out=0, out_ready=0, buffer_full=0 immediately.
- With KECCAK_PADDER_SUFFIX_PORT_EN defined, suffix=8'h1F, RATE_BITS=64: last word with byte_num=0 at cnt=1 -> out low word 32'h1F000080.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared types and constants for the Keccak stream padder.
// Rates are in bits; suffixes are the domain-separation bytes.
package keccak_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    PAD    = 2'd1,
    FULL   = 2'd2
  } pad_state_e;

  localparam logic [7:0] SHA3_SUFFIX  = 8'h06;
  localparam logic [7:0] SHAKE_SUFFIX = 8'h1F;
  localparam logic [7:0] PAD_FINAL    = 8'h80;

  localparam int RATE_SHA3_256 = 1088;
  localparam int RATE_SHA3_512 = 576;
  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;

  // Zero-extend a byte into the low end of a word.
  function automatic logic [1023:0] low_byte(
    input logic [7:0] b
  );
    return {1016'd0, b};
  endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Last-word formatter: keeps the top byte_num bytes, inserts
// the suffix byte after them and zeroes the rest.
module keccak_pad_word #(
  parameter int IN_W = 32,
  localparam int NB = IN_W / 8,
  localparam int BW = $clog2(NB)
) (
  input  logic [IN_W-1:0] in,
  input  logic [BW-1:0]   byte_num,
  input  logic [7:0]      suffix,
  output logic [IN_W-1:0] w
);

  // Byte i counts from the MSB end of the word.
  always_comb begin
    w = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < 32'(byte_num)) begin
        w[IN_W-1-8*i -: 8] = in[IN_W-1-8*i -: 8];
      end else if (i == 32'(byte_num)) begin
        w[IN_W-1-8*i -: 8] = suffix;
      end
    end
  end

endmodule

// File: rtl/keccak_padder_stream.sv
// Streaming pad10*1 padder: packs words into rate-sized blocks.
// Define KECCAK_PADDER_SUFFIX_PORT_EN for a runtime suffix port.
module keccak_padder_stream
  import keccak_pkg::*;
#(
  parameter int          IN_W      = 32,
  parameter int          RATE_BITS = 1088,
  parameter logic [7:0]  SUFFIX    = SHA3_SUFFIX,
  localparam int         BW        = $clog2(IN_W / 8)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IN_W-1:0]      in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [BW-1:0]        byte_num,
`ifdef KECCAK_PADDER_SUFFIX_PORT_EN
  input  logic [7:0]           suffix,
`endif
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_ready,
  input  logic                 f_ack
);

  localparam int WORDS = RATE_BITS / IN_W;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);
  localparam logic [IN_W-1:0] PAD_WORD =
    IN_W'(low_byte(PAD_FINAL));

  pad_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [RATE_BITS-1:0] out_q, out_d;
  logic                rdy_q, rdy_d;
  logic                full_q, full_d;

  logic [7:0]          sfx;
  logic [IN_W-1:0]     fmt;
  logic [IN_W-1:0]     word;
  logic                blk_end;

`ifdef KECCAK_PADDER_SUFFIX_PORT_EN
  assign sfx = suffix;
`else
  assign sfx = SUFFIX;
`endif

  keccak_pad_word #(
    .IN_W(IN_W)
  ) u_fmt (
    .in       (in),
    .byte_num (byte_num),
    .suffix   (sfx),
    .w        (fmt)
  );

  assign blk_end = (cnt_q == LAST_IDX);

  // Next-state, block shift and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    word    = '0;
    unique case (state_q)
      ACCEPT: begin
        if (in_ready && !full_q) begin
          word = is_last ? fmt : in;
          if (is_last && blk_end) begin
            word[7:0] = word[7:0] | PAD_FINAL;
          end
          out_d = {out_q[RATE_BITS-IN_W-1:0], word};
          cnt_d = blk_end ? '0 : cnt_q + 1'b1;
          if (blk_end) begin
            state_d = FULL;
          end else if (is_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        word  = blk_end ? PAD_WORD : '0;
        out_d = {out_q[RATE_BITS-IN_W-1:0], word};
        cnt_d = blk_end ? '0 : cnt_q + 1'b1;
        if (blk_end) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (f_ack) begin
          state_d = ACCEPT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ACCEPT;
        cnt_d   = '0;
      end
    endcase
    full_d = (state_d != ACCEPT);
    rdy_d  = (state_d == FULL);
  end

  // State, counter, block and handshake registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACCEPT;
      cnt_q   <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
      full_q  <= full_d;
    end
  end

  assign out         = out_q;
  assign out_ready   = rdy_q;
  assign buffer_full = full_q;

endmodule

// File: tb/tb_keccak_padder_stream.sv
// Bench for keccak_padder_stream: 64-bit and 1088-bit rates.
// A byte-queue model builds expected blocks for random streams.
module tb_keccak_padder_stream;

`ifdef KECCAK_PADDER_SUFFIX_PORT_EN
  localparam logic [7:0] SUF = 8'h1F;
`else
  localparam logic [7:0] SUF = 8'h06;
`endif

  logic          clk;
  logic          rst_a, rst_b;
  logic [31:0]   din;
  logic          vin, last;
  logic [1:0]    bn;
  logic          ack_a, ack_b;
  logic          bf_a, rdy_a;
  logic [63:0]   out_a;
  logic          bf_b, rdy_b;
  logic [1087:0] out_b;
`ifdef KECCAK_PADDER_SUFFIX_PORT_EN
  logic [7:0]    sfx;
`endif

  int n_run, n_fail;
  bit auto_ack;
  logic [7:0]  cur_q[$];
  logic [63:0] exp_q[$];

  keccak_padder_stream #(
    .IN_W(32), .RATE_BITS(64)
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .in(din),
    .in_ready(vin), .is_last(last), .byte_num(bn),
`ifdef KECCAK_PADDER_SUFFIX_PORT_EN
    .suffix(sfx),
`endif
    .buffer_full(bf_a), .out(out_a),
    .out_ready(rdy_a), .f_ack(ack_a)
  );

  keccak_padder_stream #(
    .IN_W(32)
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .in(din),
    .in_ready(vin), .is_last(last), .byte_num(bn),
`ifdef KECCAK_PADDER_SUFFIX_PORT_EN
    .suffix(sfx),
`endif
    .buffer_full(bf_b), .out(out_b),
    .out_ready(rdy_b), .f_ack(ack_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: message bytes, suffix, zero fill, 0x80 in last byte.
  task automatic model_push(input logic [31:0] d,
                            input logic l,
                            input logic [1:0] b);
    logic [31:0] t;
    logic [63:0] blk;
    int n;
    t = d;
    n = l ? int'(b) : 4;
    for (int i = 0; i < n; i++) begin
      cur_q.push_back(t[31:24]);
      t = t << 8;
    end
    if (l) begin
      cur_q.push_back(SUF);
      while (cur_q.size() % 8 != 0) cur_q.push_back(8'h00);
      cur_q[cur_q.size()-1] = cur_q[cur_q.size()-1] | 8'h80;
    end
    if (cur_q.size() == 8) begin
      blk = '0;
      for (int i = 0; i < 8; i++) blk = {blk[55:0], cur_q[i]};
      exp_q.push_back(blk);
      cur_q.delete();
    end
  endtask

  task automatic send(input bit sel, input logic [31:0] d,
                      input logic l, input logic [1:0] b);
    int g;
    g = 0;
    @(negedge clk);
    din = d; vin = 1'b1; last = l; bn = b;
    while ((sel ? bf_b : bf_a) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) chk("send_timeout", 1, 0);
    else if (!sel) model_push(d, l, b);
    @(negedge clk);
    vin = 1'b0; last = 1'b0;
  endtask

  task automatic pulse_ack_a();
    ack_a = 1'b1;
    @(negedge clk);
    ack_a = 1'b0;
  endtask

  // Random-phase monitor: compare each block, then ack it.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && rdy_a) begin
        chk("mon_bf", bf_a, 1);
        if (exp_q.size() != 0) chk("mon_blk", out_a, exp_q.pop_front());
        else chk("mon_extra_blk", 1, 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        chk("mon_stable", rdy_a, 1);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] w0, w1, w2;
    int g, pc;
    n_run = 0; n_fail = 0; auto_ack = 0;
    rst_a = 0; rst_b = 0;
    din = 0; vin = 0; last = 0; bn = 0;
    ack_a = 0; ack_b = 0;
`ifdef KECCAK_PADDER_SUFFIX_PORT_EN
    sfx = 8'h1F;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_a", out_a, 0);
    chk("rst_rdy_a", rdy_a, 0);
    chk("rst_bf_a", bf_a, 0);
    chk("rst_out_b", 64'(|out_b), 0);
    rst_a = 1;

    // Two words, last has one byte; ack outside FULL ignored.
    ack_a = 1'b1;
    send(0, 32'h90ABCDEF, 0, 0);
    ack_a = 1'b0;
    chk("t1_mid_rdy", rdy_a, 0);
    chk("t1_mid_low", out_a[31:0], 32'h90ABCDEF);
    send(0, 32'h12345678, 1, 1);
    chk("t1_rdy", rdy_a, 1);
    chk("t1_bf", bf_a, 1);
    chk("t1_out", out_a, {32'h90ABCDEF, 8'h12, SUF, 16'h0080});
    pulse_ack_a();
    chk("t1_ack_rdy", rdy_a, 0);
    chk("t1_ack_bf", bf_a, 0);

    // Last word first with no bytes: one pad cycle.
    send(0, 32'hDEADBEEF, 1, 0);
    chk("t2_pad_bf", bf_a, 1);
    chk("t2_pad_rdy", rdy_a, 0);
    @(negedge clk);
    chk("t2_rdy", rdy_a, 1);
    chk("t2_out", out_a, {SUF, 48'h0, 8'h80});
    pulse_ack_a();

    // Suffix and final byte share the last byte.
    send(0, 32'h11223344, 0, 0);
    send(0, 32'hAABBCCDD, 1, 3);
    chk("t3_out", out_a, {32'h11223344, 24'hAABBCC, SUF | 8'h80});
    pulse_ack_a();

    // Held in_ready: third word waits for ack.
    w0 = $urandom; w1 = $urandom; w2 = $urandom;
    @(negedge clk);
    din = w0; vin = 1; last = 0; bn = 0;
    @(negedge clk);
    din = w1;
    @(negedge clk);
    chk("t4_rdy", rdy_a, 1);
    chk("t4_out", out_a, {w0, w1});
    din = w2;
    repeat (2) @(negedge clk);
    chk("t4_hold_out", out_a, {w0, w1});
    chk("t4_hold_bf", bf_a, 1);
    ack_a = 1;
    @(negedge clk);
    ack_a = 0;
    chk("t4_ack_rdy", rdy_a, 0);
    chk("t4_ack_bf", bf_a, 0);
    chk("t4_not_taken", out_a[31:0], w1);
    @(negedge clk);
    vin = 0;
    chk("t4_taken", out_a, {w1, w2});
    send(0, 32'h01020304, 0, 0);
    chk("t4_blk2", out_a, {w2, 32'h01020304});
    pulse_ack_a();

    // Empty last word at cnt=1.
    send(0, 32'h5A5A5A5A, 0, 0);
    send(0, 32'hFFFFFFFF, 1, 0);
    chk("t6_low", out_a[31:0], {SUF, 24'h000080});
    pulse_ack_a();

    // Randomised streams against the byte model.
    rst_a = 0;
    @(negedge clk);
    rst_a = 1;
    exp_q.delete();
    cur_q.delete();
    auto_ack = 1;
    for (int m = 0; m < 30; m++) begin
      int nw;
      nw = $urandom_range(0, 5);
      for (int j = 0; j < nw; j++) begin
        send(0, $urandom, 0, 0);
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
      send(0, $urandom, 1, 2'($urandom_range(0, 3)));
    end
    g = 0;
    while ((exp_q.size() != 0 || rdy_a) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("rand_drain", 64'(exp_q.size()), 0);
    auto_ack = 0;
    rst_a = 0;

    // 1088-bit rate: last word at cnt=2 pads 31 cycles.
    @(negedge clk);
    rst_b = 1;
    w0 = $urandom; w1 = $urandom;
    send(1, w0, 0, 0);
    send(1, w1, 0, 0);
    send(1, 32'hC0FFEE99, 1, 2);
    pc = 0; g = 0;
    while (!rdy_b && g < 100) begin
      if (bf_b) pc++;
      @(negedge clk);
      g++;
    end
    chk("b_pad_cycles", 64'(pc), 31);
    chk("b_rdy", rdy_b, 1);
    chk("b_top", out_b[1087:1024], {w0, w1});
    chk("b_last", out_b[1023:992], {16'hC0FF, SUF, 8'h00});
    chk("b_mid", 64'(|out_b[991:64]), 0);
    chk("b_low", out_b[63:0], 64'h80);
    ack_b = 1;
    @(negedge clk);
    ack_b = 0;
    chk("b_ack_rdy", rdy_b, 0);

    // Reset during PAD discards the block.
    send(1, $urandom, 1, 0);
    repeat (4) @(negedge clk);
    chk("b_in_pad", bf_b, 1);
    rst_b = 0;
    #1;
    chk("b_rst_out", 64'(|out_b), 0);
    chk("b_rst_rdy", rdy_b, 0);
    chk("b_rst_bf", bf_b, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
